// File: rtl/apb_uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_uart_pkg : shared types, register offsets and access decode       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package apb_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_WR_WAIT = 3'd2,
    ST_WR_DONE = 3'd3,
    ST_RD_POP  = 3'd4,
    ST_RD_CAP  = 3'd5,
    ST_RESP    = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    ACC_TX     = 2'd0,
    ACC_RX     = 2'd1,
    ACC_STATUS = 2'd2,
    ACC_BAD    = 2'd3
  } acc_t;

  localparam logic [3:0] TXDATA_OFF      = 4'h0;
  localparam logic [3:0] RXDATA_OFF      = 4'h4;
  localparam logic [3:0] STATUS_OFF      = 4'h8;
  localparam int         DEFAULT_TIMEOUT = 255;

  // Direction is part of the decode: TXDATA is write-only, the others read-only.
  function automatic acc_t decode_access(input logic [3:0] off, input logic write);
    case (off)
      TXDATA_OFF: return write ? ACC_TX : ACC_BAD;
      RXDATA_OFF: return write ? ACC_BAD : ACC_RX;
      STATUS_OFF: return write ? ACC_BAD : ACC_STATUS;
      default:    return ACC_BAD;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_uart_slave_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_uart_slave_if : APB3 bus bundle between CPU fabric and completer  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface apb_uart_slave_if #(
  parameter int WIDTH = 32
);
  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [WIDTH-1:0] PADDR;
  logic [WIDTH-1:0] PWDATA;
  logic [1:0]       PSTRB;
  logic [WIDTH-1:0] PRDATA;
  logic             PREADY;
  logic             PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );
endinterface
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_wait_timer : 8-bit wait-state counter with terminal-count flag    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module apb_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  // tc flags the last permitted wait cycle, so the FSM leaves after TIMEOUT waits.
  localparam logic [7:0] C_TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_count <= 8'd0;
    else if (clr) r_count <= 8'd0;
    else if (en)  r_count <= r_count + 8'd1;
  end

  assign tc = (r_count == C_TC_VAL);
endmodule
`default_nettype wire

// File: rtl/apb_uart_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apb_uart_slave : APB3 completer translating bus transfers to UART     |
// | slave strobes with wait states, RX pops and error responses. Rev 1.0  |
// +----------------------------------------------------------------------+
module apb_uart_slave
  import apb_uart_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  apb_uart_slave_if.slave  apb,
  output logic [WIDTH-1:0] SLVADDR,
  output logic [WIDTH-1:0] SLVWDATA,
  output logic [1:0]       SLVSTRB,
  output logic             SLVWRITE,
  output logic             PSEL_UART,
  output logic             SLVstore_done,
  output logic             Rd_en,
  input  logic             UART_READY,
  input  logic             store_finished,
  input  logic             UART_LOAD_READY,
  input  logic             rd_empty_rx,
  input  logic [WIDTH-1:0] rd_data,
  input  logic [31:0]      UART_Regs_out
);
  state_t r_state, w_state_nxt;
  logic   r_write;
  logic   r_err, w_err_nxt;
  acc_t   w_acc;
  logic   w_tc, w_cnt_clr, w_cnt_en;
  logic   w_setup;
  logic   w_unused_load_ready;

  assign w_acc               = decode_access(SLVADDR[3:0], r_write);
  assign w_setup             = apb.PSEL && !apb.PENABLE;
  assign w_unused_load_ready = UART_LOAD_READY;

  apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_cnt_clr),
    .en    (w_cnt_en),
    .tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Losing PSEL mid-transfer abandons it silently from every waiting state.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        w_err_nxt = 1'b0;
        if (w_setup) w_state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (!apb.PSEL) w_state_nxt = ST_IDLE;
        else begin
          case (w_acc)
            ACC_TX: begin
              if (UART_READY) w_state_nxt = ST_WR_WAIT;
              else if (w_tc) begin
                w_state_nxt = ST_RESP;
                w_err_nxt   = 1'b1;
              end
            end
            ACC_RX: begin
              if (rd_empty_rx) begin
                w_state_nxt = ST_RESP;
                w_err_nxt   = 1'b1;
              end else begin
                w_state_nxt = ST_RD_POP;
              end
            end
            ACC_STATUS: begin
              w_state_nxt = ST_RESP;
              w_err_nxt   = 1'b0;
            end
            default: begin
              w_state_nxt = ST_RESP;
              w_err_nxt   = 1'b1;
            end
          endcase
        end
      end
      ST_WR_WAIT: begin
        if (!apb.PSEL)          w_state_nxt = ST_IDLE;
        else if (store_finished) w_state_nxt = ST_WR_DONE;
        else if (w_tc) begin
          w_state_nxt = ST_RESP;
          w_err_nxt   = 1'b1;
        end
      end
      ST_WR_DONE: begin
        w_state_nxt = apb.PSEL ? ST_RESP : ST_IDLE;
        w_err_nxt   = 1'b0;
      end
      ST_RD_POP: w_state_nxt = apb.PSEL ? ST_RD_CAP : ST_IDLE;
      ST_RD_CAP: begin
        w_state_nxt = apb.PSEL ? ST_RESP : ST_IDLE;
        w_err_nxt   = 1'b0;
      end
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    SLVWRITE      = 1'b0;
    PSEL_UART     = 1'b0;
    SLVstore_done = 1'b0;
    Rd_en         = 1'b0;
    apb.PREADY    = 1'b0;
    apb.PSLVERR   = 1'b0;
    w_cnt_clr     = (r_state == ST_IDLE);
    w_cnt_en      = 1'b0;
    case (r_state)
      ST_DECODE: begin
        SLVWRITE  = apb.PSEL && (w_acc == ACC_TX) && UART_READY;
        PSEL_UART = apb.PSEL && ((w_acc == ACC_TX) || ((w_acc == ACC_RX) && !rd_empty_rx));
        w_cnt_en  = apb.PSEL && (w_acc == ACC_TX) && !UART_READY;
      end
      ST_WR_WAIT: begin
        SLVWRITE  = apb.PSEL;
        PSEL_UART = apb.PSEL;
        w_cnt_en  = apb.PSEL && !store_finished;
      end
      ST_WR_DONE: begin
        SLVstore_done = apb.PSEL;
        PSEL_UART     = apb.PSEL;
      end
      ST_RD_POP: begin
        Rd_en     = apb.PSEL;
        PSEL_UART = apb.PSEL;
      end
      ST_RD_CAP: PSEL_UART = apb.PSEL;
      ST_RESP: begin
        apb.PREADY  = 1'b1;
        apb.PSLVERR = r_err;
      end
      default: ;
    endcase
  end

  // PRDATA is cleared on every new setup so failed and write transfers return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      SLVADDR    <= '0;
      SLVWDATA   <= '0;
      SLVSTRB    <= 2'b00;
      r_write    <= 1'b0;
      r_err      <= 1'b0;
      apb.PRDATA <= '0;
    end else begin
      r_err <= w_err_nxt;
      if (r_state == ST_IDLE && w_setup) begin
        SLVADDR    <= apb.PADDR;
        SLVWDATA   <= apb.PWDATA;
        SLVSTRB    <= apb.PSTRB;
        r_write    <= apb.PWRITE;
        apb.PRDATA <= '0;
      end else if (r_state == ST_DECODE && apb.PSEL && w_acc == ACC_STATUS) begin
        apb.PRDATA <= WIDTH'(UART_Regs_out);
      end else if (r_state == ST_RD_CAP && apb.PSEL) begin
        apb.PRDATA <= rd_data;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_apb_uart_slave.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_apb_uart_slave : randomized scoreboard bench with UART/FIFO models |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_apb_uart_slave;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb_uart_slave_if #(.WIDTH(32)) bus ();

  logic [31:0] SLVADDR, SLVWDATA;
  logic [1:0]  SLVSTRB;
  logic        SLVWRITE, PSEL_UART, SLVstore_done, Rd_en;
  logic        UART_READY = 1'b0;
  logic        store_finished = 1'b0;
  logic        UART_LOAD_READY = 1'b1;
  logic        rd_empty_rx = 1'b1;
  logic [31:0] rd_data = 32'd0;
  logic [31:0] UART_Regs_out = 32'd0;

  apb_uart_slave #(.WIDTH(32), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .apb             (bus),
    .SLVADDR         (SLVADDR),
    .SLVWDATA        (SLVWDATA),
    .SLVSTRB         (SLVSTRB),
    .SLVWRITE        (SLVWRITE),
    .PSEL_UART       (PSEL_UART),
    .SLVstore_done   (SLVstore_done),
    .Rd_en           (Rd_en),
    .UART_READY      (UART_READY),
    .store_finished  (store_finished),
    .UART_LOAD_READY (UART_LOAD_READY),
    .rd_empty_rx     (rd_empty_rx),
    .rd_data         (rd_data),
    .UART_Regs_out   (UART_Regs_out)
  );

  typedef struct {
    logic [31:0] prdata;
    logic        err;
    int          lat, nwr, ndone, nrd, nsel;
    logic [31:0] addr, wdata;
    logic [1:0]  strb;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  logic [31:0] rx_fifo[$];
  logic [31:0] exp_rx[$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          cur_d = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // UART side: store completes when SLVWRITE has been seen high cur_d cycles; RX FIFO pops on Rd_en.
  int k = 0;
  always @(negedge clk) begin
    if (bus.PSEL && !bus.PENABLE) k = 0;
    else if (SLVWRITE)            k++;
    store_finished = SLVWRITE && (k == cur_d);
    if (Rd_en && rx_fifo.size() != 0) rd_data = rx_fifo.pop_front();
    rd_empty_rx = (rx_fifo.size() == 0);
  end

  // Monitor: measure each transfer and compare on PREADY.
  int lat = 0, cw = 0, cd = 0, cr = 0, cs = 0;
  always @(negedge clk) begin
    if (bus.PSEL && !bus.PENABLE) begin
      lat = 0; cw = 0; cd = 0; cr = 0; cs = 0;
    end else begin
      lat++;
    end
    cw += int'(SLVWRITE);
    cd += int'(SLVstore_done);
    cr += int'(Rd_en);
    cs += int'(PSEL_UART);
    if (bus.PREADY) begin
      if (sb.size() == 0) begin
        chk("unexpected_pready", 32'd1, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        chk("latency", lat, e_mon.lat);
        chk("pslverr", {31'd0, bus.PSLVERR}, {31'd0, e_mon.err});
        chk("prdata", bus.PRDATA, e_mon.prdata);
        chk("slvwrite_cycles", cw, e_mon.nwr);
        chk("store_done_pulses", cd, e_mon.ndone);
        chk("rd_en_pulses", cr, e_mon.nrd);
        if (e_mon.nsel >= 0) chk("psel_uart_cycles", cs, e_mon.nsel);
        chk("slvaddr", SLVADDR, e_mon.addr);
        chk("slvwdata", SLVWDATA, e_mon.wdata);
        chk("slvstrb", {30'd0, SLVSTRB}, {30'd0, e_mon.strb});
      end
    end
  end

  // Reference model: outcome of one transfer from the register map and timing rules.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] strb, input logic ready, input int d,
                          input logic [31:0] regs);
    exp_t e;
    logic [3:0] off;
    logic got;
    off = addr[3:0];
    e.prdata = 32'd0; e.err = 1'b0; e.lat = 2; e.nwr = 0; e.ndone = 0; e.nrd = 0;
    e.nsel = -1; e.addr = addr; e.wdata = wdata; e.strb = strb;
    if (wr && off == 4'h0) begin
      if (!ready) begin
        e.err = 1'b1; e.lat = TO + 1;
      end else if (d <= TO + 1) begin
        e.nwr = d; e.ndone = 1; e.lat = d + 2;
      end else begin
        e.err = 1'b1; e.nwr = TO + 1; e.lat = TO + 2;
      end
    end else if (!wr && off == 4'h4) begin
      if (exp_rx.size() == 0) e.err = 1'b1;
      else begin
        e.prdata = exp_rx.pop_front(); e.lat = 4; e.nrd = 1;
      end
    end else if (!wr && off == 4'h8) begin
      e.prdata = regs;
    end else begin
      e.err = 1'b1; e.nsel = 0;
    end
    sb.push_back(e);
    UART_READY = ready; cur_d = d; UART_Regs_out = regs;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr;
    bus.PADDR = addr; bus.PWDATA = wdata; bus.PSTRB = strb;
    @(posedge clk); #1 bus.PENABLE = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = bus.PREADY;
    end
    chk("pready_seen", {31'd0, got}, 32'd1);
    if (!got) void'(sb.pop_back());
    @(posedge clk); #1;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
  endtask

  task automatic push_rx(input logic [31:0] v);
    rx_fifo.push_back(v);
    exp_rx.push_back(v);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_slvwrite"}, {31'd0, SLVWRITE}, 32'd0);
    chk({tag, "_psel_uart"}, {31'd0, PSEL_UART}, 32'd0);
    chk({tag, "_pready"}, {31'd0, bus.PREADY}, 32'd0);
    chk({tag, "_outs"}, {28'd0, SLVstore_done, Rd_en, bus.PSLVERR, |SLVSTRB}, 32'd0);
    chk({tag, "_slvaddr"}, SLVADDR, 32'd0);
    chk({tag, "_prdata"}, bus.PRDATA, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   kind;
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
    bus.PADDR = 32'd0; bus.PWDATA = 32'd0; bus.PSTRB = 2'b00;
    repeat (3) @(posedge clk);
    #1 chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    apb_xfer(1'b1, 32'h0, 32'hA5A5_0001, 2'b10, 1'b1, 4, 32'd0);
    push_rx(32'h0000_0042);
    apb_xfer(1'b0, 32'h4, 32'd0, 2'b00, 1'b1, 2, 32'd0);
    apb_xfer(1'b0, 32'h4, 32'd0, 2'b00, 1'b1, 2, 32'd0);
    apb_xfer(1'b1, 32'h0, 32'h1111_2222, 2'b01, 1'b0, 2, 32'd0);
    apb_xfer(1'b0, 32'hC, 32'd0, 2'b00, 1'b1, 2, 32'd0);
    apb_xfer(1'b1, 32'h8, 32'h5555_AAAA, 2'b11, 1'b1, 2, 32'd0);
    apb_xfer(1'b0, 32'h8, 32'd0, 2'b00, 1'b1, 2, 32'h0000_1234);
    apb_xfer(1'b1, 32'h0, 32'h0000_0009, 2'b00, 1'b1, TO + 1, 32'd0);
    apb_xfer(1'b1, 32'h0, 32'h0000_000A, 2'b00, 1'b1, TO + 2, 32'd0);

    // Reset in the middle of a store that the UART never finishes.
    UART_READY = 1'b1; cur_d = 50;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h0; bus.PWDATA = 32'hDEAD_BEEF; bus.PSTRB = 2'b11;
    @(posedge clk); #1 bus.PENABLE = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("slvwrite_before_reset", {31'd0, SLVWRITE}, 32'd1);
    rst_n = 1'b0;
    #1 chk_outputs_zero("midreset");
    bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    apb_xfer(1'b1, 32'h0, 32'h0BAD_F00D, 2'b01, 1'b1, 3, 32'd0);

    // PSEL dropped while waiting for UART_READY: no response must appear.
    UART_READY = 1'b0;
    bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
    bus.PADDR = 32'h0; bus.PWDATA = 32'h1; bus.PSTRB = 2'b00;
    @(posedge clk); #1 bus.PENABLE = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen = seen | bus.PREADY | SLVWRITE | PSEL_UART;
    end
    chk("abort_quiet", {31'd0, seen}, 32'd0);
    @(posedge clk); #1;

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 5);
      case (kind)
        0, 1: apb_xfer(1'b1, {$urandom} & 32'hFFFF_FFF0, $urandom, 2'($urandom),
                       $urandom_range(0, 3) != 0, $urandom_range(2, 11), 32'd0);
        2, 3: begin
          if ($urandom_range(0, 2) != 0) push_rx($urandom);
          apb_xfer(1'b0, ({$urandom} & 32'hFFFF_FFF0) | 32'h4, 32'd0, 2'($urandom),
                   1'b1, 2, 32'd0);
        end
        4: apb_xfer(1'b0, 32'h8, 32'd0, 2'($urandom), 1'b1, 2, $urandom);
        default: begin
          if ($urandom_range(0, 1) != 0) push_rx($urandom);
          apb_xfer(1'($urandom), $urandom, $urandom, 2'($urandom),
                   1'($urandom), $urandom_range(2, 11), $urandom);
        end
      endcase
      if ($urandom_range(0, 1) != 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
